// File: rtl/pf_pkg.sv
// Shared frame-path package.
// Holds the AXIS beat types used between the per-port filter buffers and the
// egress, the egress arbiter state encoding and the word emitted on abort.
//
// Handshake rule for every stream built on these types: a beat moves on a
// rising clk edge where tvalid and tready are both 1. A source holds tvalid,
// tdata and tlast steady until that edge. A sink may raise or drop tready in
// any cycle.
package pf_pkg;

    typedef struct packed {
        logic        tvalid;
        logic [15:0] tdata;
        logic        tlast;
    } axis_source_t;

    typedef struct packed {
        logic tready;
    } axis_sink_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_XFER  = 3'd2,
        ST_ABORT = 3'd3,
        ST_DRAIN = 3'd4
    } arb_state_t;

    // Payload of the terminating beat sent when a granted source stalls out.
    localparam logic [15:0] ABORT_TDATA = 16'h0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Searches the requests starting at the port after last_grant and wrapping,
// so the port served most recently has the lowest priority.
//
// Ports:
//   req        in   NUM_PORTS  request per port
//   last_grant in   ID_W       port granted most recently
//   any_req    out  1          at least one request is set
//   winner     out  ID_W       first requesting port after last_grant
//                              (equals last_grant when nothing requests)
module rr_arbiter #(
    parameter  int NUM_PORTS = 4,
    localparam int ID_W      = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_W-1:0]      last_grant,
    output logic                 any_req,
    output logic [ID_W-1:0]      winner
);

    logic            found;
    logic [ID_W-1:0] pos;

    always_comb begin
        any_req = |req;
        winner  = last_grant;
        found   = 1'b0;
        pos     = '0;
        // Offsets 1..NUM_PORTS so that last_grant itself is tried last.
        for (int i = 1; i <= NUM_PORTS; i++) begin
            pos = ID_W'((int'(last_grant) + i) % NUM_PORTS);
            if (!found && req[pos]) begin
                winner = pos;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_egress_arbiter.sv
// Frame egress arbiter.
// Shares one egress AXIS stream between NUM_PORTS per-port frame buffers.
// A port is granted a whole frame, round-robin, and keeps the grant until its
// tlast beat is accepted. If the granted source goes STALL_TIMEOUT cycles
// without a handshake, the arbiter sends one terminating beat
// (tdata = ABORT_TDATA, tlast = 1) on egress. It then drains and discards the
// rest of that frame from the source.
//
// Ports:
//   clk            in   1                 clock
//   reset          in   1                 synchronous, active-high reset
//   src_in         in   NUM_PORTS beats   per-port buffer output
//   src_out        out  NUM_PORTS tready  per-port ready
//   frame_ready    in   NUM_PORTS         port holds at least one complete frame
//   enable         in   1                 permit new grants
//   egress_source  out  beat              shared egress stream
//   egress_sink    in   tready            egress ready
//   grant_valid    out  1                 a port owns egress
//   grant_id       out  ID_W              owning port
//   timeout_abort  out  1                 one-cycle pulse after an abort beat is accepted
//   frames_sent    out  CNT_W             frames completed normally (wraps)
//   frames_aborted out  CNT_W             frames aborted (wraps)
//   state          out  arb_state_t       current FSM state, for observation
module frame_egress_arbiter
    import pf_pkg::*;
#(
    parameter  int NUM_PORTS     = 4,
    parameter  int STALL_TIMEOUT = 256,
    parameter  int CNT_W         = 32,
    localparam int ID_W          = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  axis_source_t [NUM_PORTS-1:0]  src_in,
    output axis_sink_t   [NUM_PORTS-1:0]  src_out,
    input  logic         [NUM_PORTS-1:0]  frame_ready,
    input  logic                          enable,
    output axis_source_t                  egress_source,
    input  axis_sink_t                    egress_sink,
    output logic                          grant_valid,
    output logic         [ID_W-1:0]       grant_id,
    output logic                          timeout_abort,
    output logic         [CNT_W-1:0]      frames_sent,
    output logic         [CNT_W-1:0]      frames_aborted,
    output arb_state_t                    state
);

    localparam int                 STALL_W    = $clog2(STALL_TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);

    arb_state_t         state_next;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    winner;
    logic               any_req;
    logic [STALL_W-1:0] stall_cnt;
    axis_source_t       sel;
    logic               hs;
    logic               stall_hit;
    logic               frame_done;
    logic               abort_taken;
    logic               release_grant;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr (
        .req        (frame_ready),
        .last_grant (last_grant),
        .any_req    (any_req),
        .winner     (winner)
    );

    assign sel       = src_in[grant_id];
    assign stall_hit = (stall_cnt == STALL_LAST);

    // A source handshake means a beat left the granted buffer. In DRAIN the
    // arbiter is always ready, so tvalid alone completes it.
    always_comb begin
        hs = 1'b0;
        case (state)
            ST_XFER:  hs = sel.tvalid & egress_sink.tready;
            ST_DRAIN: hs = sel.tvalid;
            default:  hs = 1'b0;
        endcase
    end

    // Next state, egress mux and per-port ready.
    always_comb begin
        state_next    = state;
        egress_source = '0;
        src_out       = '0;
        case (state)
            ST_IDLE: begin
                if (enable && any_req) state_next = ST_GRANT;
            end
            ST_GRANT: begin
                state_next = ST_XFER;
            end
            ST_XFER: begin
                egress_source                = sel;
                src_out[grant_id].tready     = egress_sink.tready;
                if (hs && sel.tlast)         state_next = ST_IDLE;
                else if (!hs && stall_hit)   state_next = ST_ABORT;
            end
            ST_ABORT: begin
                egress_source.tvalid = 1'b1;
                egress_source.tdata  = ABORT_TDATA;
                egress_source.tlast  = 1'b1;
                if (egress_sink.tready) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                src_out[grant_id].tready = 1'b1;
                // Either the frame end or a second stall releases the port;
                // the second stall is silent.
                if (hs && sel.tlast)       state_next = ST_IDLE;
                else if (!hs && stall_hit) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign frame_done    = (state == ST_XFER) && hs && sel.tlast;
    assign abort_taken   = (state == ST_ABORT) && egress_sink.tready;
    assign release_grant = ((state == ST_XFER) || (state == ST_DRAIN)) &&
                           (state_next == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_valid    <= 1'b0;
            grant_id       <= '0;
            last_grant     <= ID_W'(NUM_PORTS - 1);
            stall_cnt      <= '0;
            timeout_abort  <= 1'b0;
            frames_sent    <= '0;
            frames_aborted <= '0;
        end else begin
            timeout_abort <= abort_taken;

            if ((state == ST_IDLE) && (state_next == ST_GRANT)) begin
                grant_valid <= 1'b1;
                grant_id    <= winner;
            end
            if (release_grant) begin
                grant_valid <= 1'b0;
                last_grant  <= grant_id;
            end

            if (frame_done)  frames_sent    <= frames_sent + CNT_W'(1);
            if (abort_taken) frames_aborted <= frames_aborted + CNT_W'(1);

            // Counts consecutive cycles without a source handshake. It clears
            // on every state change, so each XFER/DRAIN visit starts at zero.
            if (state_next != state)
                stall_cnt <= '0;
            else if ((state == ST_XFER) || (state == ST_DRAIN))
                stall_cnt <= hs ? '0 : stall_cnt + STALL_W'(1);
            else
                stall_cnt <= '0;
        end
    end

endmodule

// File: doc/frame_egress_arbiter.md
Name: frame_egress_arbiter

Overview:
- Shares one egress AXIS stream between NUM_PORTS per-port ingress frame buffers. Each buffer sits downstream of its input FSM and filter.
- Grants whole frames, round-robin, and holds the grant until tlast.
- A stalled source is cut off by a timeout. The arbiter then emits a terminating word and drains the rest of that frame.
- Sits between the per-port filter buffers and the shared egress MAC/DMA interface.

Parameters:
- NUM_PORTS, 4, number of requesting ingress buffers (2..8)
- STALL_TIMEOUT, 256, cycles with no handshake in XFER/DRAIN before abort (>=2)
- CNT_W, 32, width of frames_sent / frames_aborted counters

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- src_in  input  axis_source_t[NUM_PORTS]  per-port buffer output (tvalid, tdata[15:0], tlast)
- src_out  output  axis_sink_t[NUM_PORTS]  per-port tready
- frame_ready  input  NUM_PORTS  port p holds at least one complete frame
- enable  input  1  permit new grants
- egress_source  output  axis_source_t  shared egress stream
- egress_sink  input  axis_sink_t  egress tready
- grant_valid  output  1  a port currently owns egress
- grant_id  output  $clog2(NUM_PORTS)  owning port
- timeout_abort  output  1  one-cycle pulse when an abort is taken
- frames_sent  output  CNT_W  frames completed normally, wraps
- frames_aborted  output  CNT_W  frames aborted, wraps

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - state=IDLE, grant_valid=0, grant_id=0
  - egress_source tvalid/tlast/tdata all 0; all src_out tready=0
  - timeout_abort=0, frames_sent=0, frames_aborted=0, stall_cnt=0
  - last_grant=NUM_PORTS-1, so port 0 has first priority
- States: IDLE, GRANT, XFER, ABORT, DRAIN.
- IDLE:
  - If enable and |frame_ready: winner = first p at or after (last_grant+1) mod NUM_PORTS with frame_ready[p].
  - Register grant_id=winner and grant_valid=1 -> GRANT.
  - Otherwise stay in IDLE. Egress tvalid=0 and all tready=0.
- GRANT: one-cycle setup, no transfer, -> XFER. Request-to-first-beat latency is 2 cycles.
- XFER:
  - Combinational passthrough: egress_source = src_in[grant_id]; src_out[grant_id].tready = egress_sink.tready; all other tready=0.
  - On handshake with tlast: frames_sent+1, last_grant=grant_id, grant_valid=0 -> IDLE next cycle. No back-to-back grant in the same cycle.
- Stall counter:
  - Increments in XFER/DRAIN on every cycle without a source handshake. Clears on any handshake and on state entry.
  - Egress backpressure (src tvalid=1, egress tready=0) also counts, so a dead egress aborts too.
- stall_cnt==STALL_TIMEOUT-1 in XFER without a handshake -> ABORT.
- ABORT:
  - Egress tvalid=1, tlast=1, tdata=16'h0000; granted source tready=0.
  - Hold until egress tready. On acceptance: timeout_abort pulses, frames_aborted+1 -> DRAIN.
- DRAIN:
  - Granted source tready=1, data discarded, egress tvalid=0.
  - Source handshake with tlast -> IDLE and last_grant=grant_id.
  - A second timeout in DRAIN -> IDLE silently (no pulse, no count).
- enable deasserted mid-frame: has no effect. The frame in progress completes; only new grants are suppressed.
- frame_ready deasserting after a grant: ignored. The grant persists until tlast or timeout.
- Single requester: re-granted each frame, with one IDLE and one GRANT cycle between frames.
- Counters wrap at 2^CNT_W modulo.
- Reset asserted mid-frame returns every output to its reset value on the next edge. No terminating word is emitted.

Decomposition:
- Shared package pf_pkg holds axis_source_t and axis_sink_t (existing) plus the arbiter state enum and the abort word constant ABORT_TDATA=16'h0000.
- Sub-module rr_arbiter: purely combinational round-robin pick. Inputs: req[NUM_PORTS], last_grant. Outputs: any_req, winner.
- The main block holds the FSM, stall counter, statistics counters and the mux.

Test Plan:
- Reset, then frame_ready=4'b0101 with 3-word frames on ports 0 and 2, egress tready=1 -> port 0 frame on egress first, then port 2. frames_sent=2. The first egress beat arrives 2 cycles after frame_ready.
- All four ports ready continuously, 2 frames each -> grant order 0,1,2,3,0,1,2,3. No interleaving of words between frames.
- Port 1 frame of 10 words, egress tready toggling every cycle -> all 10 words in order, tlast on word 10 only. Other ports see tready=0 throughout.
- Port 3 sends 2 words, then tvalid=0 for STALL_TIMEOUT cycles -> egress gets word {tdata=0, tlast=1}, timeout_abort pulses once, frames_aborted=1. The remaining port 3 words are drained up to tlast, then arbitration resumes at port 0.
- enable=0 while port 0 is mid-frame with port 1 ready -> port 0 completes, then no grant while enable=0. Port 1 is granted 2 cycles after enable returns to 1.
- Reset asserted on word 2 of a 5-word frame -> next cycle grant_valid=0, egress tvalid=0, counters 0. The next grant goes to port 0.
